fetch_prefetch_unit: RTL
========================

# fetch_prefetch_unit

Parametrised instruction fetch unit with a prefetch queue. It generates word addresses into instruction memory over a valid/ready request channel and accepts in-order responses. Each returned instruction is buffered together with its PC in a DEPTH-entry FIFO for the decode stage. It supports stalls, redirects (branch/jump), and discarding of in-flight responses made stale by a redirect. It sits between the PC logic / branch resolution and the decoder.

## Interface
- ADDR_WIDTH, 16, PC / instruction-memory word-address width
- DATA_WIDTH, 32, instruction width
- DEPTH, 4, prefetch queue entries; power of two, ≥2
- RESET_PC, 0, fetch address after reset
- clk  in  1  single clock; all state updates on posedge
- rst_n  in  1  reset, synchronous and active-low
- stall  in  1  blocks issue of new memory requests; queue drain and response acceptance continue
- redirect  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  ADDR_WIDTH  new fetch address
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  ADDR_WIDTH  word address (= fetch_pc)
- imem_resp_valid  in  1  response data valid; responses return in request order, one per request
- imem_resp_data  in  DATA_WIDTH  instruction word
- out_valid  out  1  queue head valid
- out_ready  in  1  decoder consumes head
- out_pc  out  ADDR_WIDTH  PC of head instruction
- out_inst  out  DATA_WIDTH  head instruction
- pc  out  ADDR_WIDTH  next fetch address (fetch_pc)

## Operation
- State:
  - fetch_pc: next address to request
  - resp_pc: PC of the next accepted response
  - FIFO of {pc, inst} with count 0..DEPTH
  - outstanding: requests issued, not yet answered (0..DEPTH)
  - discard: stale responses still to drop (≤ outstanding)
- Credit: issuing allowed only when count + outstanding < DEPTH. This guarantees every response has a slot; there is no response back-pressure.
- imem_req_valid = rst_n & !stall & !redirect & credit. It may drop without a handshake when stall rises.
- Request fire (valid & ready):
  - fetch_pc ← fetch_pc + 1, mod 2^ADDR_WIDTH (wraps to 0)
  - outstanding +1
- Response (imem_resp_valid):
  - outstanding −1.
  - If discard ≠ 0: discard −1 and the data is dropped.
  - Otherwise: push {resp_pc, imem_resp_data}, then resp_pc ← resp_pc + 1 (wraps).
- Pop: out_valid & out_ready removes the head.
- Redirect (highest priority, overrides push and pop):
  - FIFO cleared (count ← 0)
  - fetch_pc ← redirect_pc; resp_pc ← redirect_pc
  - discard ← outstanding − (imem_resp_valid ? 1 : 0); a response arriving in the redirect cycle is itself dropped
  - outstanding updated normally (no request fires in a redirect cycle)
- Simultaneous push and pop: count unchanged. This is legal when full, since pop frees the slot the same cycle.
- imem_resp_valid with outstanding = 0 is a protocol violation and is ignored (no state change).

## Timing
- Reset (rst_n low at posedge):
  - fetch_pc, resp_pc, pc ← RESET_PC
  - count, outstanding, discard ← 0
  - out_valid = 0, imem_req_valid = 0 while rst_n is low
  - out_pc/out_inst are don't-care while out_valid = 0
- Reset mid-operation: all in-flight responses after reset are ignored, because outstanding = 0 (the memory must also be reset).
- The first request is issued in the first cycle after reset deasserts, with address RESET_PC.
- Response-to-out_valid latency: 1 cycle (registered FIFO; no bypass).
- Redirect latency:
  - Redirect asserted in cycle N: imem_req_valid = 0 in N.
  - In cycle N+1: out_valid = 0 and imem_req_addr = redirect_pc (issued if credit allows).
- Throughput: 1 instruction/cycle sustained when memory latency ≤ DEPTH − 1 cycles and out_ready is held high.
- stall has no effect on out_valid, out_pc or out_inst.

## Test plan
- Reset, then single-cycle memory and out_ready = 1 → requests to addresses 0,1,2,…; out_pc = 0,1,2,… with matching instructions; first out_valid 2 cycles after the first request fire.
- out_ready = 0, memory always ready → exactly DEPTH (4) requests issued, then imem_req_valid stays 0; count = 4. Raising out_ready resumes issue with address 4.
- 3 requests outstanding (addresses 0x10–0x12, 3-cycle memory latency), redirect to 0x80 → the 3 stale responses are dropped. out_pc next equals 0x80, then 0x81.
- Redirect in the same cycle as a response and a pop → that response is dropped, the FIFO is empty next cycle, and discard = outstanding − 1.
- fetch_pc = 0xFFFF (ADDR_WIDTH = 16), request fires → next imem_req_addr = 0x0000; out_pc sequence 0xFFFF, 0x0000.
- stall held 5 cycles with a full queue draining → no request fires during stall; all 4 entries popped in order; issue resumes the cycle after stall falls.

Source files
------------

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch unit: issues word addresses to instruction memory under a
// credit scheme and buffers returned {pc, inst} pairs in a small FIFO for decode.
module fetch_prefetch_unit #(
   parameter int                    ADDR_WIDTH = 16,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    DEPTH      = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  stall,
   input  logic                  redirect,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [ADDR_WIDTH-1:0] imem_req_addr,
   input  logic                  imem_resp_valid,
   input  logic [DATA_WIDTH-1:0] imem_resp_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH-1:0] out_pc,
   output logic [DATA_WIDTH-1:0] out_inst,
   output logic [ADDR_WIDTH-1:0] pc
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [ADDR_WIDTH-1:0] fetch_pc;
   logic [ADDR_WIDTH-1:0] resp_pc;
   logic [CNT_W-1:0]      count, count_nxt;
   logic [CNT_W-1:0]      outstanding, outstanding_nxt;
   logic [CNT_W-1:0]      discard, discard_nxt;
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
   logic [DATA_WIDTH-1:0] inst_mem [DEPTH];

   logic             credit;
   logic [CNT_W:0]   in_use;
   logic             req_fire;
   logic             resp_take;
   logic             drop;
   logic             push;
   logic             pop;

   // Slots already promised (buffered + in flight) must stay below DEPTH so
   // every response is guaranteed a FIFO entry without back-pressure.
   assign in_use    = {1'b0, count} + {1'b0, outstanding};
   assign credit    = in_use < (CNT_W + 1)'(DEPTH);

   assign imem_req_valid = rst_n & ~stall & ~redirect & credit;
   assign imem_req_addr  = fetch_pc;
   assign pc             = fetch_pc;
   assign req_fire       = imem_req_valid & imem_req_ready;

   // A response with nothing outstanding is a protocol violation and is ignored.
   assign resp_take = imem_resp_valid & (outstanding != '0);
   assign drop      = resp_take & (discard != '0);
   assign push      = resp_take & (discard == '0) & ~redirect;

   assign out_valid = rst_n & (count != '0);
   assign out_pc    = pc_mem[rd_ptr];
   assign out_inst  = inst_mem[rd_ptr];
   assign pop       = out_valid & out_ready & ~redirect;

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can
      // leave it unassigned and infer a latch.
      outstanding_nxt = outstanding + CNT_W'(req_fire) - CNT_W'(resp_take);
      count_nxt       = count;
      discard_nxt     = discard;
      if (redirect) begin
         count_nxt   = '0;
         discard_nxt = outstanding - CNT_W'(resp_take);
      end else begin
         if (push && !pop)
            count_nxt = count + CNT_W'(1);
         else if (!push && pop)
            count_nxt = count - CNT_W'(1);
         if (drop)
            discard_nxt = discard - CNT_W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         count       <= '0;
         outstanding <= '0;
         discard     <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
      end else begin
         count       <= count_nxt;
         outstanding <= outstanding_nxt;
         discard     <= discard_nxt;
         if (redirect) begin
            fetch_pc <= redirect_pc;
            resp_pc  <= redirect_pc;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
         end else begin
            if (req_fire)
               fetch_pc <= fetch_pc + ADDR_WIDTH'(1);
            if (push) begin
               resp_pc <= resp_pc + ADDR_WIDTH'(1);
               wr_ptr  <= wr_ptr + PTR_W'(1);
            end
            if (pop)
               rd_ptr <= rd_ptr + PTR_W'(1);
         end
      end
   end

   // NOTE: the storage array is deliberately not reset; out_valid masks any
   // stale contents, and resetting it would only cost flops.
   always_ff @(posedge clk) begin
      if (rst_n && push) begin
         pc_mem[wr_ptr]   <= resp_pc;
         inst_mem[wr_ptr] <= imem_resp_data;
      end
   end

endmodule
